sb_tx_fsm: RTL

Sideband transmit sequencer, the transmit-side peer of the sideband receive FSM. Generates the 64-bit clock-pattern words that bring the link partner's receiver into decode, then sends header and optional data words of sideband packets to the serializer over a valid/ack handshake. Control parity (CP) and data parity (DP) are inserted to match the receiver's checks. Sits between the LTSM/packet encoder and the sideband serializer.

---
 rtl/sb_tx_fsm_if.sv | 29 ++
 rtl/sb_tx_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_fsm_if.sv
// Handshake bundle between the LTSM/packet encoder, sb_tx_fsm and the sideband serializer.
interface sb_tx_fsm_if;
  logic [3:0]  i_state;
  logic        i_start_pattern_req;
  logic        i_rx_pattern_samp_done;
  logic        i_pkt_valid;
  logic        i_has_data;
  logic [63:0] i_header;
  logic [63:0] i_data;
  logic        o_pkt_ready;
  logic [63:0] o_ser_data;
  logic        o_ser_valid;
  logic        i_ser_ack;
  logic        o_pattern_done;
  logic        o_pkt_sent;
  logic        o_busy;

  modport master (
    output i_state, i_start_pattern_req, i_rx_pattern_samp_done, i_pkt_valid,
           i_has_data, i_header, i_data, i_ser_ack,
    input  o_pkt_ready, o_ser_data, o_ser_valid, o_pattern_done, o_pkt_sent, o_busy
  );

  modport slave (
    input  i_state, i_start_pattern_req, i_rx_pattern_samp_done, i_pkt_valid,
           i_has_data, i_header, i_data, i_ser_ack,
    output o_pkt_ready, o_ser_data, o_ser_valid, o_pattern_done, o_pkt_sent, o_busy
  );
endinterface

// File: rtl/sb_tx_fsm.sv
// Sideband transmit sequencer: clock pattern, then header/data words with a valid/ack handshake.
// Optional macro SB_TX_PARITY_EN inserts CP/DP into header bits 62/63.
module sb_tx_fsm #(
  parameter int PATTERN_TAIL = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sb_tx_fsm_if.slave  bus
);

  localparam logic [63:0] PATTERN_WORD = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [3:0]  TAIL_LAST    = 4'(PATTERN_TAIL - 1);
  localparam logic [3:0]  GAP_LAST     = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PATTERN   = 3'd1,
    ST_PAT_TAIL  = 3'd2,
    ST_READY     = 3'd3,
    ST_SEND_HDR  = 3'd4,
    ST_SEND_DATA = 3'd5,
    ST_GAP       = 3'd6
  } state_t;

  localparam state_t AFTER_PKT = (GAP_CYCLES == 0) ? ST_READY : ST_GAP;

`ifdef SB_TX_PARITY_EN
  function automatic logic [63:0] apply_parity(input logic [63:0] hdr,
                                               input logic [63:0] data,
                                               input logic        has_data);
    logic [63:0] res;
    res     = hdr;
    res[62] = ^hdr[61:0];
    res[63] = has_data ? ^data : 1'b0;
    return res;
  endfunction
`endif

  state_t      state_r, state_nxt_s;
  logic [3:0]  tail_cnt_r, tail_cnt_nxt_s;
  logic [3:0]  gap_cnt_r, gap_cnt_nxt_s;
  logic [63:0] hdr_r, hdr_nxt_s;
  logic [63:0] data_r, data_nxt_s;
  logic        has_data_r, has_data_nxt_s;
  logic [63:0] hdr_tx_s;

  logic        pkt_ready_r, pkt_ready_nxt_s;
  logic [63:0] ser_data_r, ser_data_nxt_s;
  logic        ser_valid_r, ser_valid_nxt_s;
  logic        pattern_done_r, pattern_done_nxt_s;
  logic        pkt_sent_r, pkt_sent_nxt_s;
  logic        busy_r, busy_nxt_s;

  logic        ack_s;
  logic        abort_s;

  // An ack only counts while a word is actually on offer.
  assign ack_s   = bus.i_ser_ack & ser_valid_r;
  assign abort_s = (bus.i_state == 4'd0) && (state_r != ST_IDLE);

`ifdef SB_TX_PARITY_EN
  assign hdr_tx_s = apply_parity(hdr_nxt_s, data_nxt_s, has_data_nxt_s);
`else
  assign hdr_tx_s = hdr_nxt_s;
`endif

  // Next-state, counters, capture registers and pulses.
  always_comb begin
    state_nxt_s        = state_r;
    tail_cnt_nxt_s     = tail_cnt_r;
    gap_cnt_nxt_s      = gap_cnt_r;
    hdr_nxt_s          = hdr_r;
    data_nxt_s         = data_r;
    has_data_nxt_s     = has_data_r;
    pattern_done_nxt_s = 1'b0;
    pkt_sent_nxt_s     = 1'b0;

    if (abort_s) begin
      state_nxt_s    = ST_IDLE;
      tail_cnt_nxt_s = 4'd0;
      gap_cnt_nxt_s  = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_start_pattern_req) begin
            state_nxt_s    = ST_PATTERN;
            tail_cnt_nxt_s = 4'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PATTERN: begin
          // A word acked in the detection cycle is already the first tail word.
          if (bus.i_rx_pattern_samp_done) begin
            if (ack_s && (TAIL_LAST == 4'd0)) begin
              state_nxt_s        = ST_READY;
              pattern_done_nxt_s = 1'b1;
              tail_cnt_nxt_s     = 4'd0;
            end else begin
              state_nxt_s    = ST_PAT_TAIL;
              tail_cnt_nxt_s = ack_s ? 4'd1 : 4'd0;
            end
          end else begin
            state_nxt_s = ST_PATTERN;
          end
        end
        ST_PAT_TAIL: begin
          if (ack_s) begin
            if (tail_cnt_r == TAIL_LAST) begin
              state_nxt_s        = ST_READY;
              pattern_done_nxt_s = 1'b1;
              tail_cnt_nxt_s     = 4'd0;
            end else begin
              tail_cnt_nxt_s = tail_cnt_r + 4'd1;
            end
          end else begin
            state_nxt_s = ST_PAT_TAIL;
          end
        end
        ST_READY: begin
          if (bus.i_pkt_valid) begin
            hdr_nxt_s      = bus.i_header;
            data_nxt_s     = bus.i_data;
            has_data_nxt_s = bus.i_has_data;
            state_nxt_s    = ST_SEND_HDR;
          end else begin
            state_nxt_s = ST_READY;
          end
        end
        ST_SEND_HDR: begin
          if (ack_s) begin
            if (has_data_r) begin
              state_nxt_s = ST_SEND_DATA;
            end else begin
              state_nxt_s    = AFTER_PKT;
              pkt_sent_nxt_s = 1'b1;
              gap_cnt_nxt_s  = 4'd0;
            end
          end else begin
            state_nxt_s = ST_SEND_HDR;
          end
        end
        ST_SEND_DATA: begin
          if (ack_s) begin
            state_nxt_s    = AFTER_PKT;
            pkt_sent_nxt_s = 1'b1;
            gap_cnt_nxt_s  = 4'd0;
          end else begin
            state_nxt_s = ST_SEND_DATA;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_nxt_s   = ST_READY;
            gap_cnt_nxt_s = 4'd0;
          end else begin
            gap_cnt_nxt_s = gap_cnt_r + 4'd1;
          end
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          tail_cnt_nxt_s = 4'd0;
          gap_cnt_nxt_s  = 4'd0;
        end
      endcase
    end
  end

  // Output values derived from the upcoming state so they register alongside it.
  always_comb begin
    ser_valid_nxt_s = 1'b0;
    ser_data_nxt_s  = 64'd0;
    case (state_nxt_s)
      ST_PATTERN, ST_PAT_TAIL: begin
        ser_valid_nxt_s = 1'b1;
        ser_data_nxt_s  = PATTERN_WORD;
      end
      ST_SEND_HDR: begin
        ser_valid_nxt_s = 1'b1;
        ser_data_nxt_s  = hdr_tx_s;
      end
      ST_SEND_DATA: begin
        ser_valid_nxt_s = 1'b1;
        ser_data_nxt_s  = data_nxt_s;
      end
      default: begin
        ser_valid_nxt_s = 1'b0;
        ser_data_nxt_s  = 64'd0;
      end
    endcase
    pkt_ready_nxt_s = (state_nxt_s == ST_READY);
    busy_nxt_s      = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_READY);
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r        <= ST_IDLE;
      tail_cnt_r     <= 4'd0;
      gap_cnt_r      <= 4'd0;
      hdr_r          <= 64'd0;
      data_r         <= 64'd0;
      has_data_r     <= 1'b0;
      pkt_ready_r    <= 1'b0;
      ser_data_r     <= 64'd0;
      ser_valid_r    <= 1'b0;
      pattern_done_r <= 1'b0;
      pkt_sent_r     <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      tail_cnt_r     <= tail_cnt_nxt_s;
      gap_cnt_r      <= gap_cnt_nxt_s;
      hdr_r          <= hdr_nxt_s;
      data_r         <= data_nxt_s;
      has_data_r     <= has_data_nxt_s;
      pkt_ready_r    <= pkt_ready_nxt_s;
      ser_data_r     <= ser_data_nxt_s;
      ser_valid_r    <= ser_valid_nxt_s;
      pattern_done_r <= pattern_done_nxt_s;
      pkt_sent_r     <= pkt_sent_nxt_s;
      busy_r         <= busy_nxt_s;
    end
  end

  assign bus.o_pkt_ready    = pkt_ready_r;
  assign bus.o_ser_data     = ser_data_r;
  assign bus.o_ser_valid    = ser_valid_r;
  assign bus.o_pattern_done = pattern_done_r;
  assign bus.o_pkt_sent     = pkt_sent_r;
  assign bus.o_busy         = busy_r;

endmodule
